mac_unit: RTL and testbench

MAC_UNIT -- requirements
Module: mac_unit

---
 rtl/mac_unit_if.sv | 22 ++
 rtl/mac_unit.sv | 67 ++++++
 tb/tb_mac_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mac_unit_if.sv
// Operand/result bundle for mac_unit: the master drives the control and operands,
// the slave (the MAC) returns the registered accumulator and its sticky overflow flag.
interface mac_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  clear;
    logic                  enable;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic [DATA_WIDTH-1:0] accum_out;
    logic                  overflow;

    modport master (
        output clear, enable, a_in, b_in,
        input  accum_out, overflow
    );

    modport slave (
        input  clear, enable, a_in, b_in,
        output accum_out, overflow
    );
endinterface

// File: rtl/mac_unit.sv
// Signed multiply-accumulate, one-cycle latency, with a sticky overflow flag.
// Define MAC_SATURATE_EN to clamp overflowing results instead of wrapping.
module mac_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mac_unit_if.slave   bus
);
    localparam int W = DATA_WIDTH;

    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic signed [2*W-1:0] product;
    logic signed [2*W:0]   base_ext;
    logic signed [2*W:0]   sum;
    logic                  step_ovf;
    logic [W-1:0]          result;
    logic [W-1:0]          accum_d;
    logic [W-1:0]          accum_q;
    logic                  overflow_d;
    logic                  overflow_q;

    always_comb begin
        a_ext    = {{W{bus.a_in[W-1]}}, bus.a_in};
        b_ext    = {{W{bus.b_in[W-1]}}, bus.b_in};
        product  = a_ext * b_ext;
        base_ext = bus.clear ? '0 : {{(W+1){accum_q[W-1]}}, accum_q};
        // 2W+1 bits holds any product plus any accumulator value exactly.
        sum      = {product[2*W-1], product} + base_ext;
        // Fits in W bits only when every bit from the top down to bit W-1 agrees.
        step_ovf = !((&sum[2*W:W-1]) || !(|sum[2*W:W-1]));

`ifdef MAC_SATURATE_EN
        if (step_ovf) begin
            result = sum[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            result = sum[W-1:0];
        end
`else
        result = sum[W-1:0];
`endif

        accum_d    = accum_q;
        overflow_d = overflow_q;
        if (bus.enable) begin
            accum_d    = result;
            overflow_d = bus.clear ? step_ovf : (overflow_q | step_ovf);
        end else if (bus.clear) begin
            accum_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accum_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            accum_q    <= accum_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.accum_out = accum_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed scenarios plus randomized steps
// compared against an exact-arithmetic reference model.
module tb_mac_unit;
    localparam int W        = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   txn;
    int   acc_m;
    bit   ovf_m;

    mac_unit_if #(.DATA_WIDTH(W)) bus ();

    mac_unit #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the mathematical sum.
    task automatic model_step(input bit clr, input bit en, input int a, input int b);
        longint exact;
        bit     so;
        if (en) begin
            exact = (clr ? 64'sd0 : longint'(acc_m)) + longint'(a) * longint'(b);
            so    = (exact > SMAX) || (exact < SMIN);
`ifdef MAC_SATURATE_EN
            if (so) acc_m = (exact > 0) ? int'(SMAX) : int'(SMIN);
            else    acc_m = int'(exact);
`else
            acc_m = int'(exact);
`endif
            ovf_m = clr ? so : (ovf_m | so);
        end else if (clr) begin
            acc_m = 0;
            ovf_m = 1'b0;
        end
    endtask

    task automatic step(input bit clr, input bit en, input int a, input int b);
        @(negedge clk);
        bus.clear  = clr;
        bus.enable = en;
        bus.a_in   = a;
        bus.b_in   = b;
        model_step(clr, en, a, b);
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d clr=%0b en=%0b a=%h b=%h acc=%h ovf=%0b",
                 txn, clr, en, a, b, bus.accum_out, bus.overflow);
        check_val("accum", {32'h0, bus.accum_out}, {32'h0, acc_m});
        check_val("ovf",   {63'h0, bus.overflow},  {63'h0, ovf_m});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        txn        = 0;
        acc_m      = 0;
        ovf_m      = 1'b0;
        reset      = 1'b0;
        bus.clear  = 1'b0;
        bus.enable = 1'b1;
        bus.a_in   = 32'd9;
        bus.b_in   = 32'd9;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_accum", {32'h0, bus.accum_out}, 64'h0);
        check_val("rst_ovf",   {63'h0, bus.overflow},  64'h0);
        @(negedge clk);
        bus.enable = 1'b0;
        reset      = 1'b1;

        // Basic sequence: 12, then 42, then hold.
        step(1'b1, 1'b1, 3, 4);
        check_val("seq_12", {32'h0, bus.accum_out}, 64'd12);
        step(1'b0, 1'b1, 5, 6);
        check_val("seq_42", {32'h0, bus.accum_out}, 64'd42);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, int'($urandom), int'($urandom));
        check_val("hold_42", {32'h0, bus.accum_out}, 64'd42);

        step(1'b1, 1'b0, 7, 7);
        check_val("clear_0", {32'h0, bus.accum_out}, 64'd0);

        // Asynchronous reset pulse between edges while holding 42.
        step(1'b1, 1'b1, 6, 7);
        check_val("pre_rst_42", {32'h0, bus.accum_out}, 64'd42);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst_accum", {32'h0, bus.accum_out}, 64'd0);
        check_val("async_rst_ovf",   {63'h0, bus.overflow},  64'd0);
        acc_m = 0;
        ovf_m = 1'b0;
        // Reset must win over an enabled step across a rising edge.
        bus.clear  = 1'b0;
        bus.enable = 1'b1;
        bus.a_in   = 32'd100;
        bus.b_in   = 32'd100;
        @(posedge clk);
        #1;
        check_val("rst_override", {32'h0, bus.accum_out}, 64'd0);
        @(negedge clk);
        bus.enable = 1'b0;
        reset      = 1'b1;
        step(1'b0, 1'b1, 2, 3);
        check_val("post_rst_first", {32'h0, bus.accum_out}, 64'd6);

        step(1'b1, 1'b1, 32'hFFFF_FFFE, 7);
        check_val("neg_product", {32'h0, bus.accum_out}, 64'h0000_0000_FFFF_FFF2);
        check_val("neg_prod_ovf", {63'h0, bus.overflow}, 64'd0);

        step(1'b1, 1'b1, 32'h0001_0000, 32'h0000_8000);
        check_val("pos_ovf_flag", {63'h0, bus.overflow}, 64'd1);
`ifdef MAC_SATURATE_EN
        check_val("pos_ovf_val", {32'h0, bus.accum_out}, 64'h7FFF_FFFF);
`else
        check_val("pos_ovf_val", {32'h0, bus.accum_out}, 64'h8000_0000);
`endif
        step(1'b0, 1'b1, 0, 0);
        check_val("ovf_sticky", {63'h0, bus.overflow}, 64'd1);
        step(1'b1, 1'b1, 1, 1);
        check_val("restart_val", {32'h0, bus.accum_out}, 64'd1);
        check_val("restart_ovf", {63'h0, bus.overflow},  64'd0);

        step(1'b1, 1'b1, 32'h8000_0000, 2);
        check_val("neg_ovf_flag", {63'h0, bus.overflow}, 64'd1);
`ifdef MAC_SATURATE_EN
        check_val("neg_ovf_val", {32'h0, bus.accum_out}, 64'h8000_0000);
`else
        check_val("neg_ovf_val", {32'h0, bus.accum_out}, 64'h0);
`endif

        step(1'b1, 1'b1, 1, 2);
        step(1'b0, 1'b1, 3, 4);
        step(1'b0, 1'b1, 5, 6);
        check_val("sum_44", {32'h0, bus.accum_out}, 64'd44);

        // Randomized mix of small and full-range operands.
        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            bit clr;
            bit en;
            clr = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                a = int'($urandom);
                b = int'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                a = int'($urandom_range(0, 200)) - 100;
                b = int'($urandom_range(0, 200)) - 100;
            end else begin
                a = int'($urandom_range(0, 131072)) - 65536;
                b = int'($urandom_range(0, 131072)) - 65536;
            end
            step(clr, en, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
